keypad_scanner: RTL and testbench

Upstream input stage of the vending machine: drives the 4x4 matrix keypad columns, samples the rows, debounces, and delivers one clean key event per physical press to the vending-machine controller. Output is a 4-bit key code plus a single-cycle valid strobe. The controller consumes `key_value` only when `key_valid` is high.

---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one-hot-low columns, synchronizes and samples rows,
// debounces whole-scan results and emits one key_valid strobe per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_ONE,
        RES_MULTI
    } scan_res_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] div;
    logic [1:0]    col;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    cand;

    logic          div_tc;
    logic          scan_end;
    logic [1:0]    next_col;
    logic [2:0]    col_lows;
    logic [1:0]    col_row;
    logic [1:0]    acc_next;
    logic [3:0]    code_next;
    scan_res_t     scan_res;
    logic [CW-1:0] cnt_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign div_tc   = (div == DIV_LAST);
    assign scan_end = div_tc && (col == 2'd3);
    assign next_col = col + 2'd1;

    // Low-bit tally saturates at 2: only "none", "exactly one" and "more" matter.
    always_comb begin
        col_lows  = 3'd0;
        col_row   = 2'd0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_lows = col_lows + 3'd1;
                col_row  = 2'(r);
            end
        end
        acc_next  = acc_cnt;
        code_next = acc_code;
        if (col_lows >= 3'd2) begin
            acc_next = 2'd2;
        end else if (col_lows == 3'd1) begin
            if (acc_cnt == 2'd0) begin
                acc_next  = 2'd1;
                code_next = {col_row, col};
            end else begin
                acc_next = 2'd2;
            end
        end
    end

    always_comb begin
        scan_res = RES_NONE;
        case (acc_next)
            2'd0:    scan_res = RES_NONE;
            2'd1:    scan_res = RES_ONE;
            default: scan_res = RES_MULTI;
        endcase
    end

    assign cnt_inc = (cnt >= CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div       <= '0;
            col       <= '0;
            shift_col <= 4'b1110;
            acc_cnt   <= '0;
            acc_code  <= '0;
        end else if (div_tc) begin
            div       <= '0;
            col       <= next_col;
            shift_col <= ~(4'b0001 << next_col);
            if (col == 2'd3) begin
                acc_cnt  <= '0;
                acc_code <= '0;
            end else begin
                acc_cnt  <= acc_next;
                acc_code <= code_next;
            end
        end else begin
            div <= div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_value <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                case (state)
                    ST_IDLE: begin
                        if (scan_res == RES_ONE) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= ST_PRESSED;
                                cnt       <= '0;
                                key_value <= code_next;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= ST_DEBOUNCE;
                                cand  <= code_next;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (scan_res == RES_ONE) begin
                            if (code_next == cand) begin
                                if (cnt_inc >= CNT_MAX) begin
                                    state     <= ST_PRESSED;
                                    cnt       <= '0;
                                    key_value <= cand;
                                    key_valid <= 1'b1;
                                    key_held  <= 1'b1;
                                end else begin
                                    cnt <= cnt_inc;
                                end
                            end else begin
                                cand <= code_next;
                                cnt  <= CNT_ONE;
                            end
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (scan_res == RES_NONE) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state    <= ST_IDLE;
                                cnt      <= '0;
                                key_held <= 1'b0;
                            end else begin
                                state <= ST_RELEASE;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (scan_res == RES_NONE) begin
                            if (cnt_inc >= CNT_MAX) begin
                                state    <= ST_IDLE;
                                cnt      <= '0;
                                key_held <= 1'b0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= ST_PRESSED;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model, table-driven scan/press vectors
// and hand-written sequences for bounce, hold/repeat, multi-key and mid-press reset.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  shift_col;
    logic [3:0]  key_value;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int width_err = 0;
    int kv_err = 0;
    logic       prev_valid = 1'b0;
    logic       prev_reset = 1'b0;
    logic [3:0] prev_kv = 4'h0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .shift_col (shift_col),
        .key_value (key_value),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !shift_col[c]) row[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulse_cnt = pulse_cnt + 1;
            if (prev_valid) width_err = width_err + 1;
        end
        if (reset && prev_reset && (key_value !== prev_kv) && !key_valid) kv_err = kv_err + 1;
        prev_valid = key_valid;
        prev_reset = reset;
        prev_kv    = key_value;
    end

    typedef struct {
        int unsigned cyc;
        logic [3:0]  sc;
    } sc_vec_t;

    typedef struct {
        int unsigned r;
        int unsigned c;
        logic [3:0]  code;
    } key_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int bound, output bit found, output int lat, output logic [3:0] code);
        found = 1'b0;
        lat   = bound;
        code  = 4'h0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (key_valid) begin
                found = 1'b1;
                lat   = i;
                code  = key_value;
                break;
            end
        end
    endtask

    task automatic wait_release(input int bound, output bit found);
        found = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (!key_held) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        sc_vec_t    sv[10];
        key_vec_t   kv[5];
        bit         found;
        int         lat;
        int         base;
        int         k;
        logic [3:0] code;

        sv[0] = '{cyc: 0,  sc: 4'b1110};
        sv[1] = '{cyc: 3,  sc: 4'b1110};
        sv[2] = '{cyc: 4,  sc: 4'b1101};
        sv[3] = '{cyc: 7,  sc: 4'b1101};
        sv[4] = '{cyc: 8,  sc: 4'b1011};
        sv[5] = '{cyc: 11, sc: 4'b1011};
        sv[6] = '{cyc: 12, sc: 4'b0111};
        sv[7] = '{cyc: 15, sc: 4'b0111};
        sv[8] = '{cyc: 16, sc: 4'b1110};
        sv[9] = '{cyc: 20, sc: 4'b1101};

        kv[0] = '{r: 0, c: 1, code: 4'h1};
        kv[1] = '{r: 2, c: 3, code: 4'hB};
        kv[2] = '{r: 3, c: 3, code: 4'hF};
        kv[3] = '{r: 1, c: 0, code: 4'h4};
        kv[4] = '{r: 2, c: 2, code: 4'hA};

        pressed = '0;
        reset   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_shift_col", 32'(shift_col), 32'(4'b1110));
        check("rst_key_value", 32'(key_value), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held",  32'(key_held),  32'h0);

        @(negedge clk);
        reset = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            while (k < int'(sv[i].cyc)) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("scan_col_cyc%0d", sv[i].cyc), 32'(shift_col), 32'(sv[i].sc));
        end

        // Bounce: (r2,c3) one scan on, one scan off.
        for (int s = 0; s < 10; s++) begin
            pressed[11] = (s % 2 == 0);
            repeat (16) @(negedge clk);
        end
        pressed = '0;
        repeat (80) @(negedge clk);
        #1;
        check("bounce_pulses", 32'(pulse_cnt), 32'd0);
        check("bounce_key_value", 32'(key_value), 32'h0);
        check("bounce_key_held", 32'(key_held), 32'h0);

        // Single press (r0,c1) held for 6 scans.
        @(negedge clk);
        base = pulse_cnt;
        pressed[1] = 1'b1;
        wait_valid(67, found, lat, code);
        check("single_found", 32'(found), 32'd1);
        check("single_code", 32'(code), 32'h1);
        repeat (96 - lat) @(negedge clk);
        #1;
        check("single_held", 32'(key_held), 32'd1);
        check("single_one_pulse", 32'(pulse_cnt - base), 32'd1);
        @(negedge clk);
        pressed = '0;
        repeat (30) @(negedge clk);
        check("single_held_after_rel", 32'(key_held), 32'd1);
        wait_release(37, found);
        check("single_release", 32'(found), 32'd1);

        for (int i = 0; i < 5; i++) begin
            repeat (16) @(negedge clk);
            base = pulse_cnt;
            pressed[4*kv[i].r + kv[i].c] = 1'b1;
            wait_valid(67, found, lat, code);
            check($sformatf("tbl%0d_found", i), 32'(found), 32'd1);
            check($sformatf("tbl%0d_code", i), 32'(code), 32'(kv[i].code));
            repeat (32) @(negedge clk);
            #1;
            check($sformatf("tbl%0d_held", i), 32'(key_held), 32'd1);
            check($sformatf("tbl%0d_pulses", i), 32'(pulse_cnt - base), 32'd1);
            @(negedge clk);
            pressed = '0;
            wait_release(67, found);
            check($sformatf("tbl%0d_release", i), 32'(found), 32'd1);
        end

        // Long hold of (r3,c0), full release, re-press, then a one-scan release.
        repeat (16) @(negedge clk);
        base = pulse_cnt;
        pressed[12] = 1'b1;
        wait_valid(67, found, lat, code);
        check("hold_found", 32'(found), 32'd1);
        check("hold_code", 32'(code), 32'hC);
        repeat (200 - lat) @(negedge clk);
        #1;
        check("hold_one_pulse", 32'(pulse_cnt - base), 32'd1);
        @(negedge clk);
        pressed = '0;
        repeat (64) @(negedge clk);
        pressed[12] = 1'b1;
        wait_valid(80, found, lat, code);
        check("repeat_found", 32'(found), 32'd1);
        check("repeat_code", 32'(code), 32'hC);
        repeat (100) @(negedge clk);
        base = pulse_cnt;
        pressed = '0;
        repeat (16) @(negedge clk);
        pressed[12] = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("short_rel_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("short_rel_held", 32'(key_held), 32'd1);
        @(negedge clk);
        pressed = '0;
        wait_release(80, found);
        check("hold_release", 32'(found), 32'd1);

        // Two keys in row 1, then drop one.
        repeat (16) @(negedge clk);
        base = pulse_cnt;
        pressed[5] = 1'b1;
        pressed[6] = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("multi_no_pulse", 32'(pulse_cnt - base), 32'd0);
        @(negedge clk);
        pressed[6] = 1'b0;
        wait_valid(80, found, lat, code);
        check("multi_found", 32'(found), 32'd1);
        check("multi_code", 32'(code), 32'h5);
        repeat (16) @(negedge clk);
        pressed = '0;
        wait_release(80, found);
        check("multi_release", 32'(found), 32'd1);

        // Reset two scans into a (r0,c0) press.
        repeat (16) @(negedge clk);
        pressed[0] = 1'b1;
        repeat (32) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_shift_col", 32'(shift_col), 32'(4'b1110));
        check("midrst_key_value", 32'(key_value), 32'h0);
        check("midrst_key_valid", 32'(key_valid), 32'h0);
        check("midrst_key_held",  32'(key_held),  32'h0);
        @(negedge clk);
        pressed = '0;
        base = pulse_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("midrst_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("midrst_key_value_after", 32'(key_value), 32'h0);

        check("valid_width_violations", 32'(width_err), 32'd0);
        check("key_value_change_violations", 32'(kv_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end

endmodule
